// File: rtl/ram_bank.sv
// ram_bank: single-clock RAM bank with byte-enabled write port, registered
// read port with valid flag, and a hardware clear engine that zeroes the
// array one word per cycle after reset or on request.
// Optional feature macro: RAM_BANK_BYPASS_EN (same-address same-cycle read
// returns the post-write word; otherwise read-first).
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | sweeping mem[clr_ptr] <= 0, busy = 1, requests rejected
// IDLE  | serving reads/writes, clr_req starts a new sweep
module ram_bank #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  rd_word;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              idle;
  logic              wr_in, rd_in;
  logic              wr_ok, rd_ok;
  logic [AW-1:0]     wr_idx, rd_idx;

  assign idle   = (state_q == IDLE);
  assign wr_in  = ((wr_addr >> AW) == '0);
  assign rd_in  = ((rd_addr >> AW) == '0);
  assign wr_idx = wr_addr[AW-1:0];
  assign rd_idx = rd_addr[AW-1:0];
  assign wr_ok  = idle && wr_en && wr_in;
  assign rd_ok  = idle && rd_en && rd_in;

  // Next-state logic: sweep pointer walks the array, then hands over to IDLE
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Read word selection; bypass merges the same-cycle write into the read
  always_comb begin
    rd_word = mem[rd_idx];
`ifdef RAM_BANK_BYPASS_EN
    if (wr_ok && (wr_idx == rd_idx)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
`endif
  end

  // Read result and error pulse for the request presented this cycle
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_ok) begin
      rd_data_d  = rd_word;
      rd_valid_d = 1'b1;
    end else if (idle && rd_en) begin
      rd_data_d  = '0;
      rd_valid_d = 1'b1;
    end
    err_d = (!idle && (rd_en || wr_en)) ||
            (idle && ((rd_en && !rd_in) || (wr_en && !wr_in)));
  end

  // Array storage: clear sweep has priority, array itself is never reset
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign busy     = (state_q == CLEAR);

endmodule
